// File: rtl/mem_req_arbiter_if.sv
// Requester-side and memory-side signals of the two-port memory arbiter.
interface mem_req_arbiter_if;
  // Requester 0 (I-side) and requester 1 (D-side)
  logic        req0;
  logic        req1;
  logic [31:0] addr0;
  logic [31:0] addr1;
  logic        we0;
  logic        we1;
  logic [31:0] wdata0;
  logic [31:0] wdata1;
  logic        ack0;
  logic        ack1;
  logic [31:0] rdata0;
  logic [31:0] rdata1;
  logic        err0;
  logic        err1;
  // Shared single-port main memory
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  // Arbiter side
  modport slave (
    input  req0, req1, addr0, addr1, we0, we1, wdata0, wdata1, mem_rdata, mem_ack,
    output ack0, ack1, rdata0, rdata1, err0, err1, mem_req, mem_addr, mem_we, mem_wdata
  );

  // Requesters plus memory model side
  modport master (
    output req0, req1, addr0, addr1, we0, we1, wdata0, wdata1, mem_rdata, mem_ack,
    input  ack0, ack1, rdata0, rdata1, err0, err1, mem_req, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter between I-side and D-side requesters for a single-port memory.
// Sequences one word access at a time: ISSUE pulse, WAIT for ack or timeout, RESP pulse.
module mem_req_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input logic              clk,
  input logic              rst_n,
  mem_req_arbiter_if.slave bus
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e          state_q, state_d;
  logic            cur_id_q, cur_id_d;
  logic            last_grant_q, last_grant_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            we_q, we_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;
  logic            winner;

  // On a tie the requester that did not win last time gets the grant
  assign winner = (bus.req0 && bus.req1) ? ~last_grant_q : bus.req1;

  // Next-state logic: grant, issue, wait for ack/timeout, respond
  always_comb begin
    state_d      = state_q;
    cur_id_d     = cur_id_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    we_d         = we_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    unique case (state_q)
      StIdle: begin
        if (bus.req0 || bus.req1) begin
          state_d      = StIssue;
          cur_id_d     = winner;
          last_grant_d = winner;
          addr_d       = winner ? bus.addr1 : bus.addr0;
          wdata_d      = winner ? bus.wdata1 : bus.wdata0;
          we_d         = winner ? bus.we1 : bus.we0;
        end
      end
      StIssue: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        if (bus.mem_ack) begin
          rdata_d = we_q ? 32'h0 : bus.mem_rdata;
          err_d   = 1'b0;
          state_d = StResp;
        end else begin
          // Saturating count; the timeout fires on the cycle it reaches the limit
          if (cnt_q != CntW'(TIMEOUT_CYCLES)) begin
            cnt_d = cnt_q + 1'b1;
          end
          if (cnt_q >= CntW'(TIMEOUT_CYCLES - 1)) begin
            rdata_d = 32'h0;
            err_d   = 1'b1;
            state_d = StResp;
          end
        end
      end
      StResp: begin
        state_d = StIdle;
        addr_d  = '0;
        wdata_d = '0;
        we_d    = 1'b0;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cur_id_q     <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_id_q     <= cur_id_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
    end
  end

  // Outputs decode from state; response data is gated so it reads 0 outside ack
  assign bus.ack0      = (state_q == StResp) && !cur_id_q;
  assign bus.ack1      = (state_q == StResp) && cur_id_q;
  assign bus.rdata0    = bus.ack0 ? rdata_q : 32'h0;
  assign bus.rdata1    = bus.ack1 ? rdata_q : 32'h0;
  assign bus.err0      = bus.ack0 && err_q;
  assign bus.err1      = bus.ack1 && err_q;
  assign bus.mem_req   = (state_q == StIssue);
  assign bus.mem_we    = (state_q == StIssue) && we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter with a transaction-level reference model.
module tb_mem_req_arbiter;

  localparam int TO = 15;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } req_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_v[2];
  logic [31:0] addr_v[2];
  logic        we_v[2];
  logic [31:0] wdata_v[2];
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  mem_req_arbiter_if bus ();

  assign bus.req0      = req_v[0];
  assign bus.req1      = req_v[1];
  assign bus.addr0     = addr_v[0];
  assign bus.addr1     = addr_v[1];
  assign bus.we0       = we_v[0];
  assign bus.we1       = we_v[1];
  assign bus.wdata0    = wdata_v[0];
  assign bus.wdata1    = wdata_v[1];
  assign bus.mem_ack   = mem_ack;
  assign bus.mem_rdata = mem_rdata;

  mem_req_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: one transaction in flight, tracked by its age in cycles since grant
  // (age 1 = issue cycle, later ages = waiting, age m_end = response cycle).
  bit          m_busy;
  int          m_age;
  int          m_end;
  int          m_id;
  int          m_last;
  bit          m_fin;
  int          m_fin_id;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_we;
  logic [31:0] m_rdata;
  logic        m_err;

  // Stimulus state
  req_t q0[$];
  req_t q1[$];
  bit   rand_mode;
  int   mem_lat;
  int   late_ack_cyc = -1;
  int   req_cyc[2];

  // Observations
  int   ack_cyc[2];
  logic [31:0] ack_rd[2];
  logic ack_err[2];
  int   ack_order[$];
  int   issue_cycles[$];
  logic [31:0] issue_addr;
  logic [31:0] issue_wdata;
  int   mem_we_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0;
    m_age  = 0;
    m_end  = 0;
    m_id   = 0;
    m_last = 1;
    m_fin  = 1'b0;
  endtask

  task automatic model_step();
    cyc++;
    m_fin = 1'b0;
    if (!rst_n) begin
      model_reset();
    end else if (m_busy) begin
      if (m_age == m_end) begin
        m_busy   = 1'b0;
        m_fin    = 1'b1;
        m_fin_id = m_id;
      end else begin
        if (m_age >= 2 && m_end == 0) begin
          if (mem_ack) begin
            m_end   = m_age + 1;
            m_err   = 1'b0;
            m_rdata = m_we ? 32'h0 : mem_rdata;
          end else if (m_age == 1 + TO) begin
            m_end   = m_age + 1;
            m_err   = 1'b1;
            m_rdata = 32'h0;
          end
        end
        m_age++;
      end
    end else if (req_v[0] || req_v[1]) begin
      m_id    = (req_v[0] && req_v[1]) ? 1 - m_last : (req_v[1] ? 1 : 0);
      m_last  = m_id;
      m_busy  = 1'b1;
      m_age   = 1;
      m_end   = 0;
      m_addr  = addr_v[m_id];
      m_we    = we_v[m_id];
      m_wdata = wdata_v[m_id];
    end
  endtask

  task automatic present(input int p, input req_t r);
    req_v[p]   = 1'b1;
    addr_v[p]  = r.addr;
    we_v[p]    = r.we;
    wdata_v[p] = r.wdata;
    req_cyc[p] = cyc;
  endtask

  task automatic drive();
    req_t r;
    if (rand_mode) begin
      for (int p = 0; p < 2; p++) begin
        req_v[p]   = 1'($urandom_range(0, 1));
        we_v[p]    = 1'($urandom_range(0, 1));
        addr_v[p]  = $urandom;
        wdata_v[p] = $urandom;
      end
      mem_ack   = 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
    end else begin
      if (m_fin) req_v[m_fin_id] = 1'b0;
      if (!req_v[0] && q0.size() > 0) begin
        r = q0.pop_front();
        present(0, r);
      end
      if (!req_v[1] && q1.size() > 0) begin
        r = q1.pop_front();
        present(1, r);
      end
      mem_ack = (m_busy && m_end == 0 && mem_lat != 0 && m_age == 1 + mem_lat) ||
                (cyc == late_ack_cyc);
    end
  endtask

  task automatic compare();
    logic        e_req, e_we, e_ack0, e_ack1, e_err0, e_err1;
    logic [31:0] e_addr, e_wdata, e_rd0, e_rd1;
    bit          chk_bus;
    e_req = 0; e_we = 0; e_ack0 = 0; e_ack1 = 0; e_err0 = 0; e_err1 = 0;
    e_addr = 0; e_wdata = 0; e_rd0 = 0; e_rd1 = 0; chk_bus = 1;
    if (m_busy) begin
      if (m_age == 1) begin
        e_req   = 1'b1;
        e_we    = m_we;
        e_addr  = m_addr;
        e_wdata = m_wdata;
      end else if (m_age == m_end) begin
        chk_bus = 0;
        if (m_id == 0) begin
          e_ack0 = 1'b1; e_rd0 = m_rdata; e_err0 = m_err;
        end else begin
          e_ack1 = 1'b1; e_rd1 = m_rdata; e_err1 = m_err;
        end
      end else begin
        e_addr  = m_addr;
        e_wdata = m_wdata;
      end
    end
    check("mem_req", 32'(bus.mem_req), 32'(e_req));
    check("mem_we", 32'(bus.mem_we), 32'(e_we));
    if (chk_bus) begin
      check("mem_addr", bus.mem_addr, e_addr);
      check("mem_wdata", bus.mem_wdata, e_wdata);
    end
    check("ack0", 32'(bus.ack0), 32'(e_ack0));
    check("ack1", 32'(bus.ack1), 32'(e_ack1));
    check("rdata0", bus.rdata0, e_rd0);
    check("rdata1", bus.rdata1, e_rd1);
    check("err0", 32'(bus.err0), 32'(e_err0));
    check("err1", 32'(bus.err1), 32'(e_err1));
    if (bus.mem_req) begin
      issue_cycles.push_back(cyc);
      issue_addr  = bus.mem_addr;
      issue_wdata = bus.mem_wdata;
    end
    if (bus.mem_we) mem_we_cnt++;
    if (bus.ack0) begin
      ack_order.push_back(0); ack_cyc[0] = cyc; ack_rd[0] = bus.rdata0; ack_err[0] = bus.err0;
    end
    if (bus.ack1) begin
      ack_order.push_back(1); ack_cyc[1] = cyc; ack_rd[1] = bus.rdata1; ack_err[1] = bus.err1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    drive();
    @(negedge clk);
    compare();
  endtask

  task automatic wait_acks(input int n, input int budget);
    int start;
    start = ack_order.size();
    for (int i = 0; i < budget && ack_order.size() < start + n; i++) tick();
    check("acks_within_budget", 32'(ack_order.size() >= start + n), 32'd1);
  endtask

  function automatic req_t mk(input logic [31:0] a, input logic w, input logic [31:0] d);
    req_t r;
    r.addr = a; r.we = w; r.wdata = d;
    return r;
  endfunction

  initial begin
    int n;
    for (int p = 0; p < 2; p++) begin
      req_v[p] = 0; addr_v[p] = 0; we_v[p] = 0; wdata_v[p] = 0;
    end
    model_reset();

    // Reset held with random inputs
    rand_mode = 1;
    repeat (6) tick();
    rand_mode = 0;
    for (int p = 0; p < 2; p++) begin
      req_v[p] = 0; addr_v[p] = 0; we_v[p] = 0; wdata_v[p] = 0;
    end
    mem_ack = 0;
    mem_rdata = 0;
    rst_n = 1'b1;
    #1;
    check("post_reset_ctl", 32'({bus.ack0, bus.ack1, bus.err0, bus.err1, bus.mem_req,
                                 bus.mem_we}), 32'd0);
    check("post_reset_addr", bus.mem_addr | bus.mem_wdata, 32'd0);

    // Contention: both requesters busy for four transactions, first tie goes to 0
    mem_lat = 1;
    mem_rdata = 32'h0BAD_F00D;
    issue_cycles.delete();
    ack_order.delete();
    q0.push_back(mk(32'h1000, 1'b0, 32'h0));
    q0.push_back(mk(32'h1004, 1'b0, 32'h0));
    q1.push_back(mk(32'h2000, 1'b1, 32'h1111_2222));
    q1.push_back(mk(32'h2004, 1'b0, 32'h0));
    wait_acks(4, 60);
    check("order_len", 32'(ack_order.size()), 32'd4);
    if (ack_order.size() == 4) begin
      check("order0", 32'(ack_order[0]), 32'd0);
      check("order1", 32'(ack_order[1]), 32'd1);
      check("order2", 32'(ack_order[2]), 32'd0);
      check("order3", 32'(ack_order[3]), 32'd1);
    end
    check("issue_count", 32'(issue_cycles.size()), 32'd4);
    for (int i = 1; i < issue_cycles.size(); i++)
      check("issue_gap", 32'(issue_cycles[i] - issue_cycles[i-1]), 32'd4);
    repeat (2) tick();

    // Single read, mem_ack two cycles after mem_req
    mem_lat = 2;
    mem_rdata = 32'hDEAD_BEEF;
    n = ack_order.size();
    q0.push_back(mk(32'h0000_0010, 1'b0, 32'h0));
    wait_acks(1, 20);
    check("rd_latency", 32'(ack_cyc[0] - req_cyc[0]), 32'd4);
    check("rd_rdata", ack_rd[0], 32'hDEAD_BEEF);
    check("rd_err", 32'(ack_err[0]), 32'd0);
    check("rd_addr", issue_addr, 32'h10);
    check("rd_ack_count", 32'(ack_order.size() - n), 32'd1);
    repeat (2) tick();

    // Single write, mem_ack three cycles after mem_req
    mem_lat = 3;
    mem_rdata = 32'hFFFF_FFFF;
    mem_we_cnt = 0;
    q1.push_back(mk(32'h40, 1'b1, 32'h1234_5678));
    wait_acks(1, 20);
    check("wr_latency", 32'(ack_cyc[1] - req_cyc[1]), 32'd5);
    check("wr_rdata", ack_rd[1], 32'h0);
    check("wr_we_cycles", 32'(mem_we_cnt), 32'd1);
    check("wr_wdata", issue_wdata, 32'h1234_5678);
    repeat (2) tick();

    // Timeout, then a late ack that must be ignored
    mem_lat = 0;
    mem_rdata = 32'h5555_AAAA;
    q0.push_back(mk(32'h80, 1'b0, 32'h0));
    wait_acks(1, 40);
    check("to_latency", 32'(ack_cyc[0] - req_cyc[0]), 32'd17);
    check("to_err", 32'(ack_err[0]), 32'd1);
    check("to_rdata", ack_rd[0], 32'h0);
    n = ack_order.size();
    late_ack_cyc = cyc + 2;
    repeat (5) tick();
    check("late_ack_ignored", 32'(ack_order.size() - n), 32'd0);

    // Reset in the middle of WAIT
    mem_lat = 10;
    q0.push_back(mk(32'h100, 1'b0, 32'h0));
    repeat (4) tick();
    check("mid_wait_addr", bus.mem_addr, 32'h100);
    #2;
    rst_n = 1'b0;
    model_reset();
    q0.delete();
    q1.delete();
    req_v[0] = 0;
    req_v[1] = 0;
    #1;
    check("mid_reset_ctl", 32'({bus.ack0, bus.ack1, bus.err0, bus.err1, bus.mem_req,
                                bus.mem_we}), 32'd0);
    check("mid_reset_addr", bus.mem_addr | bus.mem_wdata, 32'd0);
    check("mid_reset_rdata", bus.rdata0 | bus.rdata1, 32'd0);
    n = ack_order.size();
    late_ack_cyc = cyc + 1;
    repeat (3) tick();
    rst_n = 1'b1;
    late_ack_cyc = cyc + 1;
    repeat (3) tick();
    check("no_stale_ack", 32'(ack_order.size() - n), 32'd0);

    // Tie after reset grants requester 0 first
    mem_lat = 1;
    mem_rdata = 32'hA5A5_0001;
    q0.push_back(mk(32'h200, 1'b0, 32'h0));
    q1.push_back(mk(32'h300, 1'b0, 32'h0));
    wait_acks(2, 30);
    check("post_tie_first", 32'(ack_order[n]), 32'd0);
    check("post_rdata0", ack_rd[0], 32'hA5A5_0001);
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
